// File: rtl/ring_pkt_sender_if.sv
// Pop-side, credit-side and status signals of the ring packet sender.
interface ring_pkt_sender_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 flush_i;
  logic                 rx_i;
  logic                 rx_ack_o;
  logic [DATA_SIZE-1:0] data_i;
  logic                 tx_o;
  logic                 credit_i;
  logic [DATA_SIZE-1:0] data_o;
  logic                 eop_o;
  logic                 busy_o;
  logic [CNT_WIDTH-1:0] pkt_count_o;

  // Environment side: feeds the buffer head and downstream credit.
  modport master (
    output flush_i, rx_i, data_i, credit_i,
    input  rx_ack_o, tx_o, data_o, eop_o, busy_o, pkt_count_o
  );

  // Framer side.
  modport slave (
    input  flush_i, rx_i, data_i, credit_i,
    output rx_ack_o, tx_o, data_o, eop_o, busy_o, pkt_count_o
  );
endinterface

// File: rtl/ring_pkt_sender.sv
// Packet framer draining a ring buffer FIFO: parses header/size/payload
// words, forwards them over a credit link with end-of-packet marking, and
// counts delivered packets.
module ring_pkt_sender #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned SIZE_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  ring_pkt_sender_if.slave bus
);

  localparam int unsigned DW = DATA_SIZE;
  localparam int unsigned SW = SIZE_WIDTH;
  localparam int unsigned CW = CNT_WIDTH;

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_SIZE,
    ST_PAYLOAD
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   remaining_q, remaining_d;
  logic [SW-1:0]   size_field;
  logic            eop_d;
  logic            pop;
  logic            xfer;

  logic [DW-1:0]   data_q;
  logic            tx_q;
  logic            eop_q;
  logic [CW-1:0]   cnt_q;

  assign size_field = bus.data_i[SW-1:0];

  // A word leaves the output register when it is valid and credited.
  assign xfer = tx_q && bus.credit_i;

  // Pop only when the output register is free or emptying this cycle;
  // never while in reset or flushing.
  assign pop = rst_ni && bus.rx_i && !bus.flush_i && (!tx_q || bus.credit_i);

  assign bus.rx_ack_o    = pop;
  assign bus.tx_o        = tx_q;
  assign bus.data_o      = data_q;
  assign bus.eop_o       = eop_q;
  assign bus.pkt_count_o = cnt_q;
  assign bus.busy_o      = (state_q != ST_HEADER) || tx_q;

  // Parser state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HEADER;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Parser next state and end-of-packet marking of the popped word.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    eop_d       = 1'b0;
    if (bus.flush_i) begin
      state_d     = ST_HEADER;
      remaining_d = '0;
    end else if (pop) begin
      unique case (state_q)
        ST_HEADER: begin
          state_d = ST_SIZE;
        end
        ST_SIZE: begin
          remaining_d = size_field;
          if (size_field == '0) begin
            eop_d   = 1'b1;
            state_d = ST_HEADER;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          remaining_d = remaining_q - SW'(1);
          if (remaining_q == SW'(1)) begin
            eop_d   = 1'b1;
            state_d = ST_HEADER;
          end
        end
        default: begin
          state_d     = ST_HEADER;
          remaining_d = '0;
        end
      endcase
    end
  end

  // Output register: load on pop, drain on transfer, drop on flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      tx_q   <= 1'b0;
      eop_q  <= 1'b0;
    end else if (bus.flush_i) begin
      tx_q  <= 1'b0;
      eop_q <= 1'b0;
    end else if (pop) begin
      data_q <= bus.data_i;
      tx_q   <= 1'b1;
      eop_q  <= eop_d;
    end else if (xfer) begin
      tx_q  <= 1'b0;
      eop_q <= 1'b0;
    end
  end

  // Delivered-packet counter; an eop transfer during flush still counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (xfer && eop_q) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_ring_pkt_sender.sv
// Directed bench for ring_pkt_sender: normal framing, credit stalls,
// zero-size packets, flush, async reset and counter wrap.
module tb_ring_pkt_sender;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ring_pkt_sender_if #(.DATA_SIZE(32), .CNT_WIDTH(8)) bus_a ();
  ring_pkt_sender_if #(.DATA_SIZE(32), .CNT_WIDTH(2)) bus_b ();

  ring_pkt_sender #(.DATA_SIZE(32), .SIZE_WIDTH(16), .CNT_WIDTH(8)) dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a.slave)
  );

  ring_pkt_sender #(.DATA_SIZE(32), .SIZE_WIDTH(16), .CNT_WIDTH(2)) dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs on dut_a, check the pop strobe, then clock.
  task automatic step_a(input string tag, input logic rx, input logic [31:0] d,
                        input logic cr, input logic fl, input logic exp_ack);
    bus_a.rx_i     = rx;
    bus_a.data_i   = d;
    bus_a.credit_i = cr;
    bus_a.flush_i  = fl;
    #1;
    check({tag, " ack"}, 64'(bus_a.rx_ack_o), 64'(exp_ack));
    tick();
  endtask

  task automatic out_a(input string tag, input logic tx, input logic [31:0] d,
                       input logic eop, input logic [7:0] cnt);
    check({tag, " tx"},   64'(bus_a.tx_o),        64'(tx));
    check({tag, " data"}, 64'(bus_a.data_o),      64'(d));
    check({tag, " eop"},  64'(bus_a.eop_o),       64'(eop));
    check({tag, " cnt"},  64'(bus_a.pkt_count_o), 64'(cnt));
  endtask

  task automatic idle_a(input string tag, input logic [7:0] cnt);
    check({tag, " tx"},   64'(bus_a.tx_o),        64'(1'b0));
    check({tag, " busy"}, 64'(bus_a.busy_o),      64'(1'b0));
    check({tag, " cnt"},  64'(bus_a.pkt_count_o), 64'(cnt));
  endtask

  logic [1:0] exp_wrap [5];

  initial begin
    exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bus_a.rx_i = 1'b0; bus_a.data_i = '0; bus_a.credit_i = 1'b0; bus_a.flush_i = 1'b0;
    bus_b.rx_i = 1'b0; bus_b.data_i = '0; bus_b.credit_i = 1'b0; bus_b.flush_i = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    out_a("reset", 1'b0, 32'h0, 1'b0, 8'd0);
    check("reset busy", 64'(bus_a.busy_o), 64'(1'b0));
    rst_n = 1'b1;
    tick();

    // 1: basic packet, full credit
    step_a("t1 w0", 1'b1, 32'hA0, 1'b1, 1'b0, 1'b1);
    out_a("t1 w0", 1'b1, 32'hA0, 1'b0, 8'd0);
    check("t1 busy", 64'(bus_a.busy_o), 64'(1'b1));
    step_a("t1 w1", 1'b1, 32'h2, 1'b1, 1'b0, 1'b1);
    out_a("t1 w1", 1'b1, 32'h2, 1'b0, 8'd0);
    step_a("t1 w2", 1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
    out_a("t1 w2", 1'b1, 32'h11, 1'b0, 8'd0);
    step_a("t1 w3", 1'b1, 32'h22, 1'b1, 1'b0, 1'b1);
    out_a("t1 w3", 1'b1, 32'h22, 1'b1, 8'd0);
    step_a("t1 end", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle_a("t1 end", 8'd1);

    // 2: credit stall while the size word is held
    step_a("t2 w0", 1'b1, 32'hA0, 1'b1, 1'b0, 1'b1);
    out_a("t2 w0", 1'b1, 32'hA0, 1'b0, 8'd1);
    step_a("t2 w1", 1'b1, 32'h2, 1'b1, 1'b0, 1'b1);
    out_a("t2 w1", 1'b1, 32'h2, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step_a("t2 stall", 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      out_a("t2 stall", 1'b1, 32'h2, 1'b0, 8'd1);
    end
    step_a("t2 w2", 1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
    out_a("t2 w2", 1'b1, 32'h11, 1'b0, 8'd1);
    step_a("t2 w3", 1'b1, 32'h22, 1'b1, 1'b0, 1'b1);
    out_a("t2 w3", 1'b1, 32'h22, 1'b1, 8'd1);
    step_a("t2 end", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle_a("t2 end", 8'd2);

    // 3: zero-size packet followed back-to-back by a one-word packet
    step_a("t3 w0", 1'b1, 32'hB0, 1'b1, 1'b0, 1'b1);
    out_a("t3 w0", 1'b1, 32'hB0, 1'b0, 8'd2);
    step_a("t3 w1", 1'b1, 32'hFFFF0000, 1'b1, 1'b0, 1'b1);
    out_a("t3 w1", 1'b1, 32'hFFFF0000, 1'b1, 8'd2);
    step_a("t3 w2", 1'b1, 32'hC0, 1'b1, 1'b0, 1'b1);
    out_a("t3 w2", 1'b1, 32'hC0, 1'b0, 8'd3);
    step_a("t3 w3", 1'b1, 32'h1, 1'b1, 1'b0, 1'b1);
    out_a("t3 w3", 1'b1, 32'h1, 1'b0, 8'd3);
    step_a("t3 w4", 1'b1, 32'h33, 1'b1, 1'b0, 1'b1);
    out_a("t3 w4", 1'b1, 32'h33, 1'b1, 8'd3);
    step_a("t3 end", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle_a("t3 end", 8'd4);

    // 4: flush mid-payload, then a fresh zero-size packet
    step_a("t4 w0", 1'b1, 32'hA0, 1'b1, 1'b0, 1'b1);
    step_a("t4 w1", 1'b1, 32'h3, 1'b1, 1'b0, 1'b1);
    step_a("t4 w2", 1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
    out_a("t4 w2", 1'b1, 32'h11, 1'b0, 8'd4);
    step_a("t4 flush", 1'b1, 32'h22, 1'b1, 1'b1, 1'b0);
    out_a("t4 flush", 1'b0, 32'h11, 1'b0, 8'd4);
    check("t4 flush busy", 64'(bus_a.busy_o), 64'(1'b0));
    step_a("t4 hdr", 1'b1, 32'hD0, 1'b1, 1'b0, 1'b1);
    out_a("t4 hdr", 1'b1, 32'hD0, 1'b0, 8'd4);
    step_a("t4 size", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    out_a("t4 size", 1'b1, 32'h0, 1'b1, 8'd4);
    step_a("t4 end", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle_a("t4 end", 8'd5);

    // 4b: eop transfer completing in the flush cycle is counted
    step_a("t4b w0", 1'b1, 32'hE0, 1'b1, 1'b0, 1'b1);
    step_a("t4b w1", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    out_a("t4b w1", 1'b1, 32'h0, 1'b1, 8'd5);
    step_a("t4b flush", 1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
    out_a("t4b flush", 1'b0, 32'h0, 1'b0, 8'd6);

    // 4c: undelivered header dropped by flush under no credit
    step_a("t4c w0", 1'b1, 32'hF0, 1'b1, 1'b0, 1'b1);
    step_a("t4c flush", 1'b1, 32'h9, 1'b0, 1'b1, 1'b0);
    out_a("t4c flush", 1'b0, 32'hF0, 1'b0, 8'd6);
    check("t4c busy", 64'(bus_a.busy_o), 64'(1'b0));

    // 5: async reset mid-payload
    step_a("t5 w0", 1'b1, 32'hF0, 1'b1, 1'b0, 1'b1);
    step_a("t5 w1", 1'b1, 32'h2, 1'b1, 1'b0, 1'b1);
    step_a("t5 w2", 1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
    out_a("t5 w2", 1'b1, 32'h44, 1'b0, 8'd6);
    bus_a.data_i = 32'h55;
    rst_n = 1'b0;
    #1;
    out_a("t5 rst", 1'b0, 32'h0, 1'b0, 8'd0);
    check("t5 rst busy", 64'(bus_a.busy_o), 64'(1'b0));
    check("t5 rst ack", 64'(bus_a.rx_ack_o), 64'(1'b0));
    tick();
    check("t5 rst ack hold", 64'(bus_a.rx_ack_o), 64'(1'b0));
    rst_n = 1'b1;
    step_a("t5 hdr", 1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
    out_a("t5 hdr", 1'b1, 32'h55, 1'b0, 8'd0);
    step_a("t5 size", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    out_a("t5 size", 1'b1, 32'h0, 1'b1, 8'd0);
    step_a("t5 end", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle_a("t5 end", 8'd1);

    // 6: 2-bit counter wrap over five zero-size packets
    bus_b.credit_i = 1'b1;
    for (int p = 0; p < 5; p++) begin
      bus_b.rx_i   = 1'b1;
      bus_b.data_i = 32'hB0 + 32'(p);
      tick();
      bus_b.data_i = 32'h0;
      tick();
      bus_b.rx_i = 1'b0;
      tick();
      check($sformatf("t6 cnt%0d", p), 64'(bus_b.pkt_count_o), 64'(exp_wrap[p]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
